wrr_credit_arbiter: RTL and testbench
=====================================

# wrr_credit_arbiter

Parametrised weighted round-robin arbiter with per-grant ack handshake, per-channel credit reload and a runtime plain/weighted mode select. Sits between N requesting channels and one shared resource (bus port, DMA engine). A granted channel keeps ownership for up to `weight` acknowledged transfers, then ownership rotates.

## Interface
- `CHANNELS`, 8: number of requesters, must be ≥ 2.
- `WEIGHT_W`, 8: bits per channel weight.
- `ID_W`, `$clog2(CHANNELS)`: width of the grant index. Derived; not overridden.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `request`  in  CHANNELS  per-channel request level.
- `weight`  in  CHANNELS*WEIGHT_W  channel c weight is at bits [c*WEIGHT_W +: WEIGHT_W].
- `mode`  in  1  0 = plain round robin, 1 = weighted.
- `ack`  in  1  resource accepted one transfer from the current owner; meaningful only while `grant_valid`=1.
- `grant`  out  CHANNELS  one-hot owner, registered.
- `grant_valid`  out  1  `grant` is nonzero.
- `grant_id`  out  ID_W  binary index of the owner, registered.
- `credit`  out  WEIGHT_W  transfers remaining for the owner, including the current one.

## Operation
- State:
  - FSM IDLE/GRANT.
  - Rotating pointer `ptr` (ID_W).
  - Owner index.
  - Credit counter (WEIGHT_W).
- Pick rule: the first asserted `request` bit, searching `ptr`, `ptr+1`, … and wrapping modulo CHANNELS.
- Credit load on pick of channel c:
  - `mode`=0: load 1.
  - `mode`=1: load `weight[c]`.
  - A weight of 0 loads as 1.
- IDLE:
  - Any request: pick, load credit, go to GRANT.
  - No request: stay in IDLE.
- GRANT, `ack`=1 with `credit` > 1 and `request[owner]`=1: decrement `credit`. Owner is unchanged and `grant` stays high.
- GRANT, `ack`=1 with `credit`=1, or `request[owner]` low, or a mode switch: set `ptr` to owner+1 (wraps), then re-pick in the same cycle from the new `ptr` using the current `request`.
  - A winner loads its credit and the grant moves with no idle bubble.
  - If the old owner is the only requester, it wins again with fresh credit.
  - No winner: go to IDLE.
- GRANT, `ack`=0 with `request[owner]`=0 (abort): set `ptr` to owner+1 and re-pick as above. No transfer is counted.
- GRANT, `ack`=0 with request held: all state is held.
- `weight` is sampled only at pick time. `mode` is sampled at pick time and at every `ack`. A change to `mode` while in GRANT takes effect at the next `ack`.
- `ack` in IDLE is ignored.

## Timing
- Reset values:
  - `grant`=0, `grant_valid`=0, `grant_id`=0, `credit`=0.
  - `ptr`=0, FSM=IDLE.
- Reset asserted mid-grant clears all outputs asynchronously. The first pick after release starts from channel 0.
- Latency from IDLE: `request` high at edge N gives `grant` valid after edge N+1.
- Handover on the last `ack` at edge N: the new owner's `grant` is valid after edge N, with zero bubble cycles.
- `grant`, `grant_id`, `grant_valid` and `credit` are always mutually consistent and change only at clock edges.
- `credit` never underflows. The decrement happens only when `credit` > 1.

## Structure
- Package `wrr_pkg` holds:
  - The state enum `wrr_state_t` (IDLE, GRANT).
  - The helper `function automatic clamp_weight` (0→1).
- Sub-module `rr_priority_pick`:
  - Combinational rotating priority encoder.
  - Inputs: `request`, `ptr`.
  - Outputs: `found`, `pick_id`, `pick_onehot`.
  - Instantiated once and shared by the IDLE pick and the handover re-pick.

## Test plan
- Reset and idle: hold `request`=0 → all outputs 0. Raise `request[2]` at edge N → `grant`=4'b0100, `grant_id`=2 after edge N+1.
- Weighted sequence: CHANNELS=4, weights {1,2,3,0}, `mode`=1, all requesting, `ack` every cycle → owner sequence 0,1,1,2,2,2,3,0,… with no bubbles.
- Plain round robin: same setup with `mode`=0 → owner sequence 0,1,2,3,0. `credit` reads 1 throughout.
- Abort: channel 1 owns with weight 3. After one `ack`, drop `request[1]` → next edge `grant_id`=2 (channel 2 requesting), `credit`=weight[2].
- Sole requester: only channel 3 requests, weight 2, `ack` every cycle → `grant` stays 4'b1000 continuously. `credit` follows 2,1,2,1.
- Async reset mid-transfer: assert `reset` between edges while `credit`=2 → outputs clear immediately. After release with all requesting, the first owner is channel 0.

Source files
------------

// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin credit arbiter.
// Combinational helpers only; no latency or backpressure of its own.
package wrr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } wrr_state_t;

    // A zero weight still has to allow one transfer, otherwise the owner could never be served.
    function automatic int unsigned clamp_weight(input int unsigned w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping.
// Purely combinational, zero latency; no backpressure.
module rr_priority_pick
    import wrr_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int ID_W     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] request,
    input  logic [ID_W-1:0]     ptr,
    output logic                found,
    output logic [ID_W-1:0]     pick_id,
    output logic [CHANNELS-1:0] pick_onehot
);

    logic [ID_W-1:0] idx;

    always_comb begin
        found       = 1'b0;
        pick_id     = '0;
        pick_onehot = '0;
        idx         = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = ID_W'((int'(ptr) + i) % CHANNELS);
            if (!found && request[idx]) begin
                found            = 1'b1;
                pick_id          = idx;
                pick_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_credit_arbiter.sv
// Weighted round-robin arbiter: owner keeps the grant for up to weight acked transfers.
// Grant one edge after request from idle, zero-bubble handover on the last ack; ack=0 holds ownership.
module wrr_credit_arbiter
    import wrr_pkg::*;
#(
    parameter int  CHANNELS = 8,
    parameter int  WEIGHT_W = 8,
    localparam int ID_W     = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          request,
    input  logic [CHANNELS*WEIGHT_W-1:0] weight,
    input  logic                         mode,
    input  logic                         ack,
    output logic [CHANNELS-1:0]          grant,
    output logic                         grant_valid,
    output logic [ID_W-1:0]              grant_id,
    output logic [WEIGHT_W-1:0]          credit
);

    wrr_state_t            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [WEIGHT_W-1:0]   credit_q, credit_d;
    logic [CHANNELS-1:0]   grant_q, grant_d;
    logic                  mode_q, mode_d;

    logic                  in_grant;
    logic                  owner_req;
    logic                  handover;
    logic                  take_pick;
    logic [ID_W-1:0]       owner_nxt;
    logic [ID_W-1:0]       pick_ptr;
    logic                  found;
    logic [ID_W-1:0]       pick_id;
    logic [CHANNELS-1:0]   pick_onehot;
    logic [WEIGHT_W-1:0]   w_sel;
    logic [WEIGHT_W-1:0]   load_credit;

    assign in_grant  = (state_q == GRANT);
    assign owner_req = request[owner_q];
    assign owner_nxt = (owner_q == ID_W'(CHANNELS - 1)) ? '0 : owner_q + ID_W'(1);

    // Losing the request aborts; otherwise ownership ends on the last credit or a mode change seen at ack.
    assign handover  = in_grant &&
                       (!owner_req || (ack && ((credit_q <= WEIGHT_W'(1)) || (mode != mode_q))));
    assign pick_ptr  = in_grant ? owner_nxt : ptr_q;
    assign take_pick = found && (!in_grant || handover);

    rr_priority_pick #(
        .CHANNELS (CHANNELS),
        .ID_W     (ID_W)
    ) u_pick (
        .request     (request),
        .ptr         (pick_ptr),
        .found       (found),
        .pick_id     (pick_id),
        .pick_onehot (pick_onehot)
    );

    assign w_sel       = weight[int'(pick_id) * WEIGHT_W +: WEIGHT_W];
    assign load_credit = mode ? WEIGHT_W'(clamp_weight(32'(w_sel))) : WEIGHT_W'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        credit_d = credit_q;
        grant_d  = grant_q;
        mode_d   = mode_q;
        if (handover) begin
            ptr_d = owner_nxt;
        end
        if (take_pick) begin
            state_d  = GRANT;
            owner_d  = pick_id;
            grant_d  = pick_onehot;
            credit_d = load_credit;
            mode_d   = mode;
        end else if (handover) begin
            state_d  = IDLE;
            owner_d  = '0;
            grant_d  = '0;
            credit_d = '0;
        end else if (in_grant && ack) begin
            credit_d = credit_q - WEIGHT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            credit_q <= '0;
            grant_q  <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
            mode_q   <= mode_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = in_grant;
    assign grant_id    = owner_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_wrr_credit_arbiter.sv
// Bench for wrr_credit_arbiter: directed scenarios plus randomized run against a reference model.
module tb_wrr_credit_arbiter;

    localparam int N  = 4;
    localparam int WW = 8;

    logic            clk     = 1'b0;
    logic            reset   = 1'b0;
    logic [N-1:0]    request = '0;
    logic [N*WW-1:0] weight  = '0;
    logic            mode    = 1'b0;
    logic            ack     = 1'b0;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic [WW-1:0]   credit;

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner -1 means nobody holds the resource.
    int m_owner, m_credit, m_ptr;
    logic m_mode;

    always #5 clk = ~clk;

    wrr_credit_arbiter #(.CHANNELS(N), .WEIGHT_W(WW)) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .weight      (weight),
        .mode        (mode),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .credit      (credit)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        request = '0;
        ack     = 1'b0;
        mode    = 1'b0;
        weight  = '0;
        step();
        reset = 1'b0;
    endtask

    function automatic int first_req(input int from, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_load(input int c);
        int w;
        w        = int'(weight[c*WW +: WW]);
        m_owner  = c;
        m_mode   = mode;
        m_credit = (!mode || w == 0) ? 1 : w;
    endtask

    task automatic model_step();
        int c;
        if (m_owner < 0) begin
            c = first_req(m_ptr, request);
            if (c >= 0) model_load(c);
        end else if (!request[m_owner] || (ack && (m_credit == 1 || mode != m_mode))) begin
            m_ptr = (m_owner + 1) % N;
            c     = first_req(m_ptr, request);
            if (c >= 0) model_load(c);
            else begin
                m_owner  = -1;
                m_credit = 0;
            end
        end else if (ack) begin
            m_credit = m_credit - 1;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({grant, grant_valid, grant_id, credit} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got grant=%b vld=%b id=%0d credit=%0d want all 0",
                     grant, grant_valid, grant_id, credit);
        end
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({grant, grant_valid, grant_id, credit} !== '0) begin
                failures++;
                $display("FAIL idle_outputs got grant=%b vld=%b id=%0d credit=%0d want all 0",
                         grant, grant_valid, grant_id, credit);
            end
        end
        request = 4'b0100;
        #1;
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL grant_before_edge got vld=%b want 0", grant_valid);
        end
        step();
        checks++;
        if (grant !== 4'b0100 || grant_id !== 2'd2 || grant_valid !== 1'b1 || credit !== 8'd1) begin
            failures++;
            $display("FAIL first_grant got grant=%b id=%0d vld=%b credit=%0d want 0100/2/1/1",
                     grant, grant_id, grant_valid, credit);
        end
    endtask

    task automatic test_weighted();
        int exp_id[10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
        int exp_cr[10] = '{1, 2, 1, 3, 2, 1, 1, 1, 2, 1};
        logic [N-1:0] exp_g;
        do_reset();
        weight  = {8'd0, 8'd3, 8'd2, 8'd1};
        mode    = 1'b1;
        request = 4'hF;
        ack     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_g = '0;
            exp_g[exp_id[i]] = 1'b1;
            checks++;
            if (grant_id !== 2'(exp_id[i]) || grant !== exp_g || grant_valid !== 1'b1 ||
                credit !== 8'(exp_cr[i])) begin
                failures++;
                $display("FAIL weighted_seq[%0d] got id=%0d grant=%b vld=%b credit=%0d want id=%0d grant=%b credit=%0d",
                         i, grant_id, grant, grant_valid, credit, exp_id[i], exp_g, exp_cr[i]);
            end
        end
    endtask

    task automatic test_plain();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        do_reset();
        weight  = {8'd0, 8'd3, 8'd2, 8'd1};
        mode    = 1'b0;
        request = 4'hF;
        ack     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (grant_id !== 2'(exp_id[i]) || grant_valid !== 1'b1 || credit !== 8'd1) begin
                failures++;
                $display("FAIL plain_seq[%0d] got id=%0d vld=%b credit=%0d want id=%0d credit=1",
                         i, grant_id, grant_valid, credit, exp_id[i]);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        weight  = {8'd1, 8'd5, 8'd3, 8'd1};
        mode    = 1'b1;
        request = 4'b0110;
        step();
        checks++;
        if (grant_id !== 2'd1 || credit !== 8'd3) begin
            failures++;
            $display("FAIL abort_setup got id=%0d credit=%0d want 1/3", grant_id, credit);
        end
        ack = 1'b1;
        step();
        checks++;
        if (grant_id !== 2'd1 || credit !== 8'd2) begin
            failures++;
            $display("FAIL abort_one_ack got id=%0d credit=%0d want 1/2", grant_id, credit);
        end
        ack     = 1'b0;
        request = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || grant_id !== 2'd2 || credit !== 8'd5) begin
            failures++;
            $display("FAIL abort_handover got grant=%b id=%0d credit=%0d want 0100/2/5",
                     grant, grant_id, credit);
        end
        ack = 1'b0;
        step();
        checks++;
        if (grant_id !== 2'd2 || credit !== 8'd5) begin
            failures++;
            $display("FAIL hold_no_ack got id=%0d credit=%0d want 2/5", grant_id, credit);
        end
    endtask

    task automatic test_sole_and_async_reset();
        int exp_cr[6] = '{2, 1, 2, 1, 2, 1};
        do_reset();
        weight  = {8'd2, 8'd0, 8'd0, 8'd0};
        mode    = 1'b1;
        request = 4'b1000;
        ack     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (grant !== 4'b1000 || credit !== 8'(exp_cr[i])) begin
                failures++;
                $display("FAIL sole_req[%0d] got grant=%b credit=%0d want 1000/%0d",
                         i, grant, credit, exp_cr[i]);
            end
        end
        step();
        checks++;
        if (credit !== 8'd2) begin
            failures++;
            $display("FAIL pre_reset_credit got %0d want 2", credit);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({grant, grant_valid, grant_id, credit} !== '0) begin
            failures++;
            $display("FAIL async_reset got grant=%b vld=%b id=%0d credit=%0d want all 0",
                     grant, grant_valid, grant_id, credit);
        end
        request = 4'hF;
        step();
        reset = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0001 || grant_id !== 2'd0 || credit !== 8'd1) begin
            failures++;
            $display("FAIL after_reset_owner got grant=%b id=%0d credit=%0d want 0001/0/1",
                     grant, grant_id, credit);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g;
        do_reset();
        m_owner  = -1;
        m_credit = 0;
        m_ptr    = 0;
        m_mode   = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) request = N'($urandom_range(0, 15));
            for (int c = 0; c < N; c++) weight[c*WW +: WW] = WW'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            ack = ($urandom_range(0, 3) != 0);
            step();
            model_step();
            exp_g = '0;
            if (m_owner >= 0) exp_g[m_owner] = 1'b1;
            checks++;
            if (grant !== exp_g) begin
                failures++;
                $display("FAIL rand_grant cyc=%0d got %b want %b", cyc, grant, exp_g);
            end
            checks++;
            if (grant_valid !== (m_owner >= 0)) begin
                failures++;
                $display("FAIL rand_valid cyc=%0d got %b want %b", cyc, grant_valid, m_owner >= 0);
            end
            checks++;
            if (grant_id !== 2'((m_owner < 0) ? 0 : m_owner)) begin
                failures++;
                $display("FAIL rand_id cyc=%0d got %0d want %0d", cyc, grant_id, (m_owner < 0) ? 0 : m_owner);
            end
            checks++;
            if (credit !== 8'(m_credit)) begin
                failures++;
                $display("FAIL rand_credit cyc=%0d got %0d want %0d", cyc, credit, m_credit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_weighted();
        test_plain();
        test_abort();
        test_sole_and_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
